// File: rtl/mux_pipeline_pkg.sv
// Shared definitions for the pipelined-mux arbiter slice.
//   f_mux_latency : register stages of a recursive MUX_SIZE-ary mux tree
//                   covering INPUT_COUNT inputs (one stage per tree level).
//   ST_*          : arbiter state encoding.
package mux_pipeline_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_DELIVER = 2'd2;

  // Each tree level reduces the number of candidates by MUX_SIZE (rounding
  // up); the number of levels needed to reach one survivor is the latency.
  function automatic int f_mux_latency(input int n_inputs, input int mux_size);
    int stages;
    int remaining;
    stages    = 0;
    remaining = n_inputs;
    while (remaining > 1) begin
      remaining = (remaining + mux_size - 1) / mux_size;
      stages    = stages + 1;
    end
    return stages;
  endfunction

endpackage

// File: rtl/mux_pipeline.sv
// mux_pipeline: fixed-latency pipelined multiplexer (TYPE 0 = every tree
// level registered). Latency is f_mux_latency(INPUT_COUNT, MUX_SIZE).
//   i_clk  : clock
//   i_sel  : select index, expected stable while a word travels the tree
//   i_data : input words, slice i at [i*WIDTH +: WIDTH]
//   o_data : selected word, LATENCY cycles later (not reset)
module mux_pipeline
  import mux_pipeline_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int INPUT_COUNT = 10,
  parameter int MUX_SIZE    = 2,
  parameter int TYPE        = 0,
  localparam int GW = $clog2(INPUT_COUNT)
) (
  input  logic                         i_clk,
  input  logic [GW-1:0]                i_sel,
  input  logic [WIDTH*INPUT_COUNT-1:0] i_data,
  output logic [WIDTH-1:0]             o_data
);

  localparam int LAT  = f_mux_latency(INPUT_COUNT, MUX_SIZE);
  localparam int SB   = (MUX_SIZE > 1) ? $clog2(MUX_SIZE) : 1;
  localparam int PADN = MUX_SIZE ** LAT;
  localparam int SW   = SB * LAT;

  logic [SW-1:0]    w_sel;
  logic [WIDTH-1:0] w_leaf  [PADN];
  logic [WIDTH-1:0] r_stage [LAT][PADN];

  assign w_sel = SW'(i_sel);

  // Pad the input set up to a full tree; missing leaves read as zero.
  always_comb begin
    for (int i = 0; i < PADN; i++) w_leaf[i] = '0;
    for (int i = 0; i < INPUT_COUNT; i++) w_leaf[i] = i_data[i*WIDTH +: WIDTH];
  end

  // Level s consumes select bits [s*SB +: SB]; the low bits pick among
  // neighbouring leaves first. Slots above a level's node count are idle.
  always_ff @(posedge i_clk) begin
    for (int j = 0; j < PADN; j++) begin
      if (j < PADN / MUX_SIZE)
        r_stage[0][j] <= w_leaf[j*MUX_SIZE + int'(w_sel[0 +: SB])];
      else
        r_stage[0][j] <= '0;
    end
    for (int s = 1; s < LAT; s++) begin
      for (int j = 0; j < PADN; j++) begin
        if (j < PADN / (MUX_SIZE ** (s+1)))
          r_stage[s][j] <= r_stage[s-1][j*MUX_SIZE + int'(w_sel[s*SB +: SB])];
        else
          r_stage[s][j] <= '0;
      end
    end
  end

  assign o_data = r_stage[LAT-1][0];

endmodule

// File: rtl/mux_pipeline_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search.
//   i_req   : request vector, one bit per requester
//   i_ptr   : index the search starts from (must be < INPUT_COUNT)
//   o_idx   : first set index at or after i_ptr, wrapping modulo INPUT_COUNT
//   o_found : at least one request bit is set
module rr_pick #(
  parameter int INPUT_COUNT = 10,
  localparam int GW = $clog2(INPUT_COUNT)
) (
  input  logic [INPUT_COUNT-1:0] i_req,
  input  logic [GW-1:0]          i_ptr,
  output logic [GW-1:0]          o_idx,
  output logic                   o_found
);

  int w_cand;

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    for (int k = 0; k < INPUT_COUNT; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= INPUT_COUNT) w_cand = w_cand - INPUT_COUNT;
      if (!o_found && i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = GW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/mux_pipeline_arbiter.sv
// mux_pipeline_arbiter: round-robin arbiter/sequencer in front of a shared
// pipelined mux. One requester is granted at a time; its select is held
// until the mux pipeline has settled, then the word is offered downstream.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req_valid    : per-requester word valid
//   o_req_ready    : one-hot acceptance pulse to the grantee
//   i_req_lock     : keep the grant for another word (MUX_PIPELINE_ARB_LOCK_EN)
//   i_in_data      : requester words, slice i at [i*WIDTH +: WIDTH]
//   o_out_valid    : o_out_data holds the granted word
//   i_out_ready    : downstream accepts
//   o_out_data     : mux output
//   o_grant_id     : index being served (the mux select)
//   o_busy         : arbiter not idle
// Build option: define MUX_PIPELINE_ARB_LOCK_EN to enable grant locking.
module mux_pipeline_arbiter
  import mux_pipeline_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int INPUT_COUNT = 10,
  parameter int MUX_SIZE    = 2,
  localparam int GW = $clog2(INPUT_COUNT)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [INPUT_COUNT-1:0]       i_req_valid,
  output logic [INPUT_COUNT-1:0]       o_req_ready,
  input  logic [INPUT_COUNT-1:0]       i_req_lock,
  input  logic [WIDTH*INPUT_COUNT-1:0] i_in_data,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [WIDTH-1:0]             o_out_data,
  output logic [GW-1:0]                o_grant_id,
  output logic                         o_busy
);

  localparam int LAT = f_mux_latency(INPUT_COUNT, MUX_SIZE);
  localparam int CW  = $clog2(LAT + 1);

  logic [1:0]    r_state;
  logic [GW-1:0] r_grant_id;
  logic [GW-1:0] r_rr_ptr;
  logic [CW-1:0] r_hold_cnt;
  logic [GW-1:0] w_pick_idx;
  logic          w_pick_found;
  logic          w_relock;

  rr_pick #(.INPUT_COUNT(INPUT_COUNT)) u_rr_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  mux_pipeline #(
    .WIDTH       (WIDTH),
    .INPUT_COUNT (INPUT_COUNT),
    .MUX_SIZE    (MUX_SIZE),
    .TYPE        (0)
  ) u_mux (
    .i_clk  (i_clk),
    .i_sel  (r_grant_id),
    .i_data (i_in_data),
    .o_data (o_out_data)
  );

  // A locked grantee with another word already on its slice keeps the grant.
`ifdef MUX_PIPELINE_ARB_LOCK_EN
  assign w_relock = i_req_lock[r_grant_id] && i_req_valid[r_grant_id];
`else
  logic w_unused_lock;
  assign w_unused_lock = ^i_req_lock;
  assign w_relock      = 1'b0;
`endif

  // Grant/hold/deliver sequencer. hold_cnt counts the pipeline fill so that
  // DELIVER is entered exactly LAT edges after the grant edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_found) begin
            r_grant_id <= w_pick_idx;
            r_hold_cnt <= CW'(LAT - 1);
            r_state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == '0) r_state    <= ST_DELIVER;
          else                  r_hold_cnt <= r_hold_cnt - 1'b1;
        end
        ST_DELIVER: begin
          if (i_out_ready) begin
            if (w_relock) begin
              r_hold_cnt <= CW'(LAT - 1);
              r_state    <= ST_HOLD;
            end else begin
              r_rr_ptr <= (r_grant_id == GW'(INPUT_COUNT - 1)) ? '0 : r_grant_id + 1'b1;
              r_state  <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The acceptance pulse is the downstream handshake itself, routed back.
  always_comb begin
    o_req_ready = '0;
    if (r_state == ST_DELIVER && i_out_ready) o_req_ready[r_grant_id] = 1'b1;
  end

  assign o_out_valid = (r_state == ST_DELIVER);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_grant_id  = r_grant_id;

endmodule

// File: doc/mux_pipeline_arbiter.md
# mux_pipeline_arbiter

- Round-robin arbiter and sequencer wrapped around one fixed-latency pipelined multiplexer (TYPE 0).
- Accepts a valid/ready request from each of INPUT_COUNT requesters and grants one at a time.
- Holds the grantee's data and the mux select stable until the pipeline has settled.
- Presents the selected word downstream with a valid/ready handshake; sits between independent producers and a single shared consumer.

## Interface
- WIDTH, 4, data bits per requester
- INPUT_COUNT, 10, number of requesters; must be ≥2
- MUX_SIZE, 2, mux fan-in per stage; power of two
- MUX_LATENCY, package function of (INPUT_COUNT, MUX_SIZE), register stages in the mux; 4 for the defaults
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  INPUT_COUNT  requester i has a word on in_data slice i
- req_ready  out  INPUT_COUNT  one-hot, one-cycle acceptance pulse to the grantee
- req_lock  in  INPUT_COUNT  keep grant for the next transaction (see Configuration)
- in_data  in  WIDTH*INPUT_COUNT  requester words, slice i at [i*WIDTH +: WIDTH]
- out_valid  out  1  out_data is the granted word
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  mux output
- grant_id  out  $clog2(INPUT_COUNT)  index being served; equals mux select
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, HOLD, DELIVER.
- IDLE: if any req_valid, pick the first set index at or after rr_ptr, wrapping modulo INPUT_COUNT.
  - Register that index into grant_id/mux select, load hold_cnt = MUX_LATENCY-1, go to HOLD.
  - If no req_valid, stay in IDLE.
- HOLD: grant_id frozen; decrement hold_cnt; at 0 go to DELIVER.
- DELIVER: out_valid = 1.
  - When out_ready: req_ready[grant_id] = 1 (combinational from state and out_ready, this cycle only); rr_ptr ← (grant_id+1) mod INPUT_COUNT; go to IDLE.
  - Without out_ready: hold indefinitely with out_data stable.
- Requester protocol: req_valid and its in_data slice are stable from assertion until req_ready. The arbiter never aborts a grant.
  - A requester dropping valid early is a protocol violation. out_data is then undefined; the state machine still completes normally.
- Non-grantees' data may change freely.
- Wrap: index INPUT_COUNT-1 granted → rr_ptr = 0.
- Simultaneous new req_valid during HOLD/DELIVER: ignored until IDLE.

## Timing
- Reset values: state = IDLE, grant_id = 0, rr_ptr = 0, hold_cnt = 0, out_valid = 0, req_ready = 0, busy = 0.
  - out_data reflects the mux registers and is not reset.
- Grant registered on the edge leaving IDLE (edge E0).
- out_valid rises MUX_LATENCY cycles after E0.
- Minimum transaction (out_ready held high) = MUX_LATENCY+2 cycles IDLE-to-IDLE, one word per transaction.
- Reset asserted mid-transaction: immediate return to reset values; no req_ready issued; rr_ptr back to 0.

## Configuration
- MUX_PIPELINE_ARB_LOCK_EN defined: in DELIVER with out_ready, if req_lock[grant_id] and req_valid[grant_id] are both high in that cycle:
  - go directly to HOLD with the same grant_id and hold_cnt = MUX_LATENCY-1;
  - rr_ptr unchanged;
  - the new word must already be on the bus that cycle.
- Not defined: req_lock is ignored (unused input); behaviour is pure round-robin.

## Structure
- Shared package (mux_pipeline_pkg) holds:
  - f_mux_latency(INPUT_COUNT, MUX_SIZE), the stage count of the recursive mux tree;
  - the state encoding constants ST_IDLE, ST_HOLD, ST_DELIVER.
- One natural sub-module, rr_pick: combinational first-set-at-or-after-pointer search returning index and found flag.
- The existing mux_pipeline is instantiated as the datapath with TYPE 0, sel = grant_id.

## Test plan
- Defaults, only req_valid[3] set, in_data slice 3 = 4'hA, out_ready = 1:
  - out_valid rises 4 cycles after grant with out_data = 4'hA;
  - req_ready = 10'b0000001000 for one cycle;
  - busy falls next cycle.
- All ten valid, slice i = i, out_ready = 1:
  - served order 0,1,…,9,0 (rr wrap);
  - each transaction exactly 6 cycles.
- req_valid = 10'b1000000001 with rr_ptr = 5: grant 9 first, then 0.
- out_ready low for 7 cycles in DELIVER: out_valid stays 1, out_data stable, no req_ready; completes on the first cycle out_ready is high.
- rst_n low during HOLD of grant 6:
  - outputs return to reset values asynchronously, no req_ready[6];
  - after release with only 6 valid, grant 6 completes normally.
- With MUX_PIPELINE_ARB_LOCK_EN, req_lock[2] and req_valid[2] held, req_valid[4] also set: three consecutive grants to 2 (5 cycles each after the first), then 4 once lock drops. Without the macro: alternating 2,4.
